// File: rtl/systolic_feed_receiver.sv
// -----------------------------------------------------------------------------
// systolic_feed_receiver
//
// Array-side receiver for the SRAM controller's systolic interface.
//   * Weight beats are turned into LANES row writes into the PE array.
//   * Input beats are split into 8-bit lanes; lane k is delayed k extra cycles
//     so the array sees a diagonal wavefront.
//   * Controller protocol violations are flagged with a one-cycle pulse.
//
// Optional feature (compile-time macro RX_BEAT_COUNT_EN):
//   adds output beat_count, the number of beats accepted in the current or
//   most recent stream (saturates at MAX_VECTORS, cleared by an accepted
//   start_array and by reset).
//
// Parameters:
//   LANES        number of 8-bit lanes per beat (>= 2)
//   MAX_VECTORS  maximum input beats per inference stream
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   start_weights  one-cycle pulse: weight load begins
//   start_array    one-cycle pulse: input stream begins
//   enable         beat qualifier for systolic_data
//   systolic_data  beat payload; lane k = bits [8k+7:8k]
//   w_row_data     weight row to array
//   w_row_valid    row write strobe
//   w_row_idx      row number 0..LANES-1
//   weights_ready  all rows loaded
//   array_in       skewed operand lanes
//   lane_valid     per-lane operand valid
//   stream_done    one-cycle pulse after the skew network has drained
//   busy           receiver not idle
//   protocol_err   one-cycle pulse on a controller violation
//   beat_count     (RX_BEAT_COUNT_EN only) accepted beats of the last stream
// -----------------------------------------------------------------------------
module systolic_feed_receiver #(
  parameter int LANES       = 8,
  parameter int MAX_VECTORS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_weights,
  input  logic                       start_array,
  input  logic                       enable,
  input  logic [8*LANES-1:0]         systolic_data,
  output logic [8*LANES-1:0]         w_row_data,
  output logic                       w_row_valid,
  output logic [$clog2(LANES)-1:0]   w_row_idx,
  output logic                       weights_ready,
  output logic [8*LANES-1:0]         array_in,
  output logic [LANES-1:0]           lane_valid,
  output logic                       stream_done,
  output logic                       busy,
  output logic                       protocol_err
`ifdef RX_BEAT_COUNT_EN
  ,
  output logic [6:0]                 beat_count
`endif
);

  localparam int DW    = 8 * LANES;
  localparam int ROW_W = $clog2(LANES);
  localparam int VEC_W = $clog2(MAX_VECTORS + 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t            state_reg;
  logic [ROW_W-1:0]  row_cnt_reg;
  logic [VEC_W-1:0]  vec_cnt_reg;
  // Number of clock edges since the last accepted beat while draining.
  logic [ROW_W-1:0]  drain_cnt_reg;
  logic              weights_ready_reg;
  logic              protocol_err_reg;
  logic              stream_done_reg;
  logic              w_row_valid_reg;
  logic [DW-1:0]     w_row_data_reg;
  logic [ROW_W-1:0]  w_row_idx_reg;

  // A beat enters the skew network only while streaming; the FSM leaves
  // STREAM on the beat that reaches MAX_VECTORS, so no count check is needed.
  logic beat_in;
  assign beat_in = (state_reg == STREAM) && enable;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      row_cnt_reg       <= '0;
      vec_cnt_reg       <= '0;
      drain_cnt_reg     <= '0;
      weights_ready_reg <= 1'b0;
      protocol_err_reg  <= 1'b0;
      stream_done_reg   <= 1'b0;
      w_row_valid_reg   <= 1'b0;
      w_row_data_reg    <= '0;
      w_row_idx_reg     <= '0;
    end else begin
      protocol_err_reg <= 1'b0;
      stream_done_reg  <= 1'b0;
      w_row_valid_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start_weights) begin
            // start_weights wins a tie, but the simultaneous start_array
            // is still a violation.
            state_reg         <= LOAD_W;
            weights_ready_reg <= 1'b0;
            row_cnt_reg       <= '0;
            if (start_array) protocol_err_reg <= 1'b1;
          end else if (start_array) begin
            if (weights_ready_reg) begin
              state_reg   <= STREAM;
              vec_cnt_reg <= '0;
            end else begin
              protocol_err_reg <= 1'b1;
            end
          end
        end

        LOAD_W: begin
          if (start_weights || start_array) protocol_err_reg <= 1'b1;
          if (enable) begin
            w_row_data_reg  <= systolic_data;
            w_row_valid_reg <= 1'b1;
            w_row_idx_reg   <= row_cnt_reg;
            row_cnt_reg     <= row_cnt_reg + ROW_W'(1);
            if (row_cnt_reg == ROW_W'(LANES - 1)) begin
              weights_ready_reg <= 1'b1;
              state_reg         <= IDLE;
            end
          end
        end

        STREAM: begin
          if (start_weights || start_array) protocol_err_reg <= 1'b1;
          if (enable) begin
            vec_cnt_reg <= vec_cnt_reg + VEC_W'(1);
            if (vec_cnt_reg == VEC_W'(MAX_VECTORS - 1)) begin
              // Last allowed beat is being accepted on this edge.
              state_reg     <= DRAIN;
              drain_cnt_reg <= '0;
            end
          end else if (vec_cnt_reg != '0) begin
            // Gap detected one edge after the last beat.
            state_reg     <= DRAIN;
            drain_cnt_reg <= ROW_W'(1);
          end
        end

        DRAIN: begin
          if (enable || start_weights || start_array) protocol_err_reg <= 1'b1;
          // The last beat reaches the final lane LANES-1 edges after it was
          // accepted; one more edge later the lane is empty and done fires.
          if (drain_cnt_reg == ROW_W'(LANES - 1)) begin
            stream_done_reg <= 1'b1;
            state_reg       <= IDLE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + ROW_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skew network: lane gi is a (gi+1)-deep delay line of its byte plus valid.
  // Invalid slots carry zero so idle lanes drive 0.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] dly_data_reg [gi+1];
      logic       dly_valid_reg [gi+1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s <= gi; s++) begin
            dly_data_reg[s]  <= 8'd0;
            dly_valid_reg[s] <= 1'b0;
          end
        end else begin
          dly_data_reg[0]  <= beat_in ? systolic_data[8*gi +: 8] : 8'd0;
          dly_valid_reg[0] <= beat_in;
          for (int s = 1; s <= gi; s++) begin
            dly_data_reg[s]  <= dly_data_reg[s-1];
            dly_valid_reg[s] <= dly_valid_reg[s-1];
          end
        end
      end

      assign array_in[8*gi +: 8] = dly_data_reg[gi];
      assign lane_valid[gi]      = dly_valid_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_row_data    = w_row_data_reg;
  assign w_row_valid   = w_row_valid_reg;
  assign w_row_idx     = w_row_idx_reg;
  assign weights_ready = weights_ready_reg;
  assign stream_done   = stream_done_reg;
  assign protocol_err  = protocol_err_reg;
  assign busy          = (state_reg != IDLE);

`ifdef RX_BEAT_COUNT_EN
  // The vector counter never exceeds MAX_VECTORS, is cleared by an accepted
  // start_array and holds after the stream, which is exactly beat_count.
  assign beat_count = 7'(vec_cnt_reg);
`endif

endmodule

// File: doc/systolic_feed_receiver.md
Name: systolic_feed_receiver

Overview:
- Array-side receiver for the SRAM controller's systolic interface: consumes `start_weights`, `start_array`, `enable` and 64-bit `systolic_data` beats.
- Weight beats become 8 row writes into the PE array.
- Input beats become per-lane skewed operands: lane i is delayed i cycles, giving the diagonal wavefront an 8x8 output-stationary/weight-stationary array needs.
- Also flags protocol violations by the controller.

Parameters:
- LANES, 8, array width; number of 8-bit lanes per beat (systolic_data width = 8*LANES).
- MAX_VECTORS, 64, maximum input beats per inference stream.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start_weights  input  1  one-cycle pulse: weight load begins
- start_array  input  1  one-cycle pulse: input stream begins
- enable  input  1  beat qualifier for systolic_data
- systolic_data  input  64  beat payload; lane k = bits [8k+7:8k]
- w_row_data  output  64  weight row to array
- w_row_valid  output  1  row write strobe
- w_row_idx  output  3  row number 0..7
- weights_ready  output  1  all 8 rows loaded
- array_in  output  64  skewed operand lanes
- lane_valid  output  8  per-lane operand valid
- stream_done  output  1  one-cycle pulse after skew drained
- busy  output  1  state != IDLE
- protocol_err  output  1  one-cycle pulse on violation

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, state IDLE, row/vector counters 0, skew registers 0.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE:
  - start_weights -> LOAD_W; clears weights_ready and row counter.
  - start_array with weights_ready=1 -> STREAM.
  - start_array with weights_ready=0 -> protocol_err pulse; stay IDLE.
  - Both asserted together -> start_weights wins and protocol_err pulses.
- LOAD_W:
  - Each cycle with enable=1 latches one row.
  - Beat sampled at edge t: w_row_data/w_row_valid/w_row_idx valid in cycle t+1.
  - w_row_idx = row counter 0..7; counter increments per beat.
  - 8th beat (idx 7) -> weights_ready=1 in cycle t+1, back to IDLE. No timeout; enable gaps allowed.
  - Any start_* while in LOAD_W -> protocol_err; ignored.
- STREAM:
  - Each enable=1 beat enters the skew network.
  - Lane k value of a beat sampled at edge t appears on array_in[8k+7:8k], with lane_valid[k]=1, in cycle t+1+k.
  - Lanes without valid data drive 0 with lane_valid bit 0.
  - Vector counter counts beats.
  - First enable=0 cycle after at least one beat -> DRAIN.
  - Reaching MAX_VECTORS beats -> DRAIN. Any further enable=1 beats are dropped and each pulses protocol_err.
- DRAIN:
  - Counts LANES-1 cycles so lane 7 emits its last operand.
  - stream_done pulses in the cycle after lane_valid[7] last falls; then IDLE.
  - Beats (enable=1) in DRAIN are dropped with protocol_err.
- weights_ready persists across streams; it is cleared only by start_weights or reset.
- Reset mid-operation returns to IDLE immediately and clears weights_ready.
- lane_valid for back-to-back beats is continuous; gaps in enable propagate as gaps per lane, preserving skew.

Optional Feature:
- Macro: RX_BEAT_COUNT_EN.
- Defined:
  - Adds output port `beat_count`, 7 bits.
  - Counts input beats accepted in the current or most recent stream, saturating at MAX_VECTORS.
  - Cleared on start_array and on reset; holds after stream_done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, start_weights, then 8 beats 0x0101..01 .. 0x0808..08 with enable every cycle -> w_row_idx 0..7 one cycle after each beat, matching data; weights_ready=1 after the 8th; busy falls.
- start_array with weights_ready=0 -> protocol_err one cycle, state stays IDLE, no lane_valid.
- After weights load: start_array, one beat 0x0706050403020100 -> lane k outputs value k at cycle t+1+k; stream_done pulses 9 cycles after sampling.
- Stream of 3 beats with a 1-cycle enable gap after beat 1 -> transition to DRAIN at the gap; only 1 beat streamed; stream_done correct; protocol_err if enable returns during DRAIN.
- MAX_VECTORS=4, feed 6 consecutive beats -> 4 streamed, 2 protocol_err pulses; with RX_BEAT_COUNT_EN, beat_count=4.
- Assert rst during STREAM with data in skew -> all outputs 0 same cycle; weights_ready=0; a new start_array then flags protocol_err.
